// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit owning the HI/LO registers.
//   MULT/MULTU use one shift-add step per cycle and DIV/DIVU one restoring step
//   per cycle. An operation occupies 32 RUN cycles, and the result lands in HI/LO
//   together with a one-cycle done pulse.
// Optional feature: define MDU_DIV_EN to build the divider. Without it, a
//   start with op[1]=1 is a no-op.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start, op      launch request; op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a, src_b   rs/rt operands (src_a also carries MTHI/MTLO data)
//   mthi, mtlo     move src_a into HI/LO (only while idle)
//   flush          abort the in-flight operation / suppress a same-cycle start
//   busy           operation in progress
//   done           one-cycle pulse when HI/LO take a new result
//   hi, lo         HI/LO architectural registers
module mdu_hilo (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    hi_d, lo_d;
  logic            done_d;

  logic            launch_ok;
  logic            launch;
  logic            in_signed;
  logic [W-1:0]    init_src;
  logic [W-1:0]    init_mag;
  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;
  logic [2*W-1:0]  mul_res;
  logic [2*W-1:0]  step;
  logic [W-1:0]    res_hi, res_lo;

  assign busy = (state_q == RUN);

  // Operand signs and magnitudes; signed ops work on magnitudes throughout.
  assign a_neg = ~op_q[0] & a_q[W-1];
  assign b_neg = ~op_q[0] & b_q[W-1];
  assign a_mag = a_neg ? (~a_q + W'(1)) : a_q;

  // Accumulator seed at launch: the multiplier for multiply, the dividend for divide.
  assign in_signed = ~op[0];
  assign init_src  = op[1] ? src_a : src_b;
  assign init_mag  = (in_signed & init_src[W-1]) ? (~init_src + W'(1)) : init_src;

  // Shift-add step: conditionally add the multiplicand into the upper half, then shift right.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_mag} : (W+1)'(0));
  assign mul_next = {mul_sum, acc_q[W-1:1]};
  assign mul_res  = (a_neg ^ b_neg) ? (~step + (2*W)'(1)) : step;

`ifdef MDU_DIV_EN
  logic [W-1:0]    b_mag;
  logic [W:0]      rem_sh;
  logic [W+1:0]    diff;
  logic [2*W-1:0]  div_next;
  logic [W-1:0]    q_fix, r_fix;

  assign launch_ok = 1'b1;
  assign b_mag     = b_neg ? (~b_q + W'(1)) : b_q;

  // Restoring step: acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
  assign rem_sh = {acc_q[2*W-1:W], acc_q[W-1]};
  assign diff   = {1'b0, rem_sh} - {2'b00, b_mag};
  always_comb begin
    if (!diff[W+1]) div_next = {diff[W-1:0], acc_q[W-2:0], 1'b1};
    else            div_next = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
  end

  assign step = op_q[1] ? div_next : mul_next;

  // Sign fix: the quotient truncates toward zero and the remainder follows the dividend.
  assign q_fix = (a_neg ^ b_neg) ? (~step[W-1:0] + W'(1)) : step[W-1:0];
  assign r_fix = a_neg ? (~step[2*W-1:W] + W'(1)) : step[2*W-1:W];

  always_comb begin
    if (!op_q[1]) begin
      res_hi = mul_res[2*W-1:W];
      res_lo = mul_res[W-1:0];
    end else if (b_q == '0) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_hi = r_fix;
      res_lo = q_fix;
    end
  end
`else
  logic unused_div;

  assign launch_ok  = ~op[1];
  assign step       = mul_next;
  assign res_hi     = mul_res[2*W-1:W];
  assign res_lo     = mul_res[W-1:0];
  // Only the sign of the divisor operand and no divide opcode bit are needed here.
  assign unused_div = ^{op_q[1], b_q[W-2:0]};
`endif

  assign launch = start & ~flush & launch_ok;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi;
    lo_d    = lo;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = RUN;
          cnt_d   = '0;
          op_d    = op;
          a_d     = src_a;
          b_d     = src_b;
          acc_d   = {W'(0), init_mag};
        end else begin
          if (mthi) hi_d = src_a;
          if (mtlo) lo_d = src_a;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + CW'(1);
          // The final iteration's step feeds HI/LO directly so the result lands with done.
          if (cnt_q == CW'(W-1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
            hi_d    = res_hi;
            lo_d    = res_lo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi      <= hi_d;
      lo      <= lo_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: table-driven directed bench for mdu_hilo plus hand-written
//   sequences for moves, ignored starts, flush and mid-operation reset.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo, flush;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi, m_lo;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  mdu_hilo dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .mthi(mthi), .mtlo(mtlo), .flush(flush), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered at a negedge; drives start for one cycle and checks the whole timeline.
  task automatic run_op(input vec_t v);
    int bad;
    op = v.op; src_a = v.a; src_b = v.b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (v.op[1] && !DIV_EN) begin
      bad = 0;
      for (int i = 0; i < 36; i++) begin
        if (busy !== 1'b0 || done !== 1'b0) bad++;
        @(negedge clk);
      end
      check({v.name, "_noop_idle"}, 64'(bad), 64'd0);
      check({v.name, "_noop_hilo"}, {hi, lo}, {m_hi, m_lo});
    end else begin
      bad = 0;
      for (int i = 1; i <= 32; i++) begin
        if (busy !== 1'b1 || done !== 1'b0) bad++;
        @(negedge clk);
      end
      check({v.name, "_busy_window"}, 64'(bad), 64'd0);
      check({v.name, "_done_busy"}, {62'd0, done, busy}, 64'b10);
      check({v.name, "_hilo"}, {hi, lo}, {v.ehi, v.elo});
      m_hi = v.ehi; m_lo = v.elo;
      @(negedge clk);
      check({v.name, "_done_pulse"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    int dones;
    int bad;
    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    op = 2'b00; src_a = '0; src_b = '0;
    vecs[0]  = '{"multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{"mult_m2x3",   2'b00, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[2]  = '{"mult_minsq",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3]  = '{"multu_shift", 2'b01, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780};
    vecs[4]  = '{"mult_m1x5",   2'b00, 32'hFFFF_FFFF, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFFB};
    vecs[5]  = '{"div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[6]  = '{"divu_by0",    2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    vecs[7]  = '{"div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[8]  = '{"divu_100_7",  2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[9]  = '{"div_7_m2",    2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[10] = '{"div_10_3",    2'b10, 32'd10,        32'd3,         32'd1,         32'd3};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;

    // Moves while idle.
    mthi = 1'b1; src_a = 32'h1234;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi", {hi, lo}, {32'h1234, 32'h0});
    check("mthi_no_done", 64'(done), 64'd0);
    mtlo = 1'b1; src_a = 32'h55;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo", {hi, lo}, {32'h1234, 32'h55});
    mthi = 1'b1; mtlo = 1'b1; src_a = 32'hA;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_mtlo_both", {hi, lo}, {32'hA, 32'hA});
    m_hi = 32'hA; m_lo = 32'hA;

    for (int i = 0; i < 11; i++) run_op(vecs[i]);

    // MTHI, then MULTU 2*3 with a second start and a move while busy.
    mthi = 1'b1; src_a = 32'h1234;
    @(negedge clk);
    mthi = 1'b0; op = 2'b01; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done === 1'b1) dones++;
      if (c == 5) begin
        start = 1'b1; mthi = 1'b1; op = 2'b01; src_a = 32'd7; src_b = 32'd7;
      end
      if (c == 6) begin
        start = 1'b0; mthi = 1'b0;
        check("mthi_while_busy", 64'(hi), 64'h1234);
      end
      if (c == 33) check("seq_multu_2x3", {31'd0, done, hi, lo}, {31'd1, 1'b1, 32'd0, 32'd6});
      @(negedge clk);
    end
    check("seq_one_done", 64'(dones), 64'd1);
    check("seq_idle_after", 64'(busy), 64'd0);
    m_hi = 32'd0; m_lo = 32'd6;

    // Start and moves in the same idle cycle: start wins.
    op = 2'b01; src_a = 32'd3; src_b = 32'd5; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check("start_wins_move", {31'd0, busy, hi, lo}, {31'd0, 1'b1, m_hi, m_lo});
    bad = 1;
    for (int c = 0; c < 40 && bad != 0; c++) begin
      @(negedge clk);
      if (done === 1'b1) bad = 0;
    end
    check("start_wins_timeout", 64'(bad), 64'd0);
    check("start_wins_result", {hi, lo}, {32'd0, 32'd15});
    m_hi = 32'd0; m_lo = 32'd15;
    @(negedge clk);

    // Flush at T+10.
    op = DIV_EN ? 2'b11 : 2'b01; src_a = 32'd50; src_b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_hilo", {31'd0, busy, hi, lo}, {32'd0, m_hi, m_lo});
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(dones), 64'd0);

    // Flush in idle suppresses a same-cycle start.
    op = 2'b01; src_a = 32'd9; src_b = 32'd9; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_idle_start", {31'd0, busy, hi, lo}, {32'd0, m_hi, m_lo});

    // Reset at T+5 of an operation.
    mthi = 1'b1; mtlo = 1'b1; src_a = 32'hABCD;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("pre_reset_move", {hi, lo}, {32'hABCD, 32'hABCD});
    op = 2'b01; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_op_reset", {31'd0, busy, hi, lo}, 64'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      @(negedge clk);
    end
    check("reset_no_done", 64'(dones), 64'd0);

    // Reset overrides start and moves.
    rst = 1'b1; start = 1'b1; mthi = 1'b1; op = 2'b01; src_a = 32'h77; src_b = 32'd2;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; mthi = 1'b0;
    check("reset_overrides", {31'd0, busy, hi, lo}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_hilo.md
MDU_HILO -- requirements
Module: mdu_hilo

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset; port names follow the codebase (clk, rst).
REQ-002 clk  input  1  pipeline clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  EX-stage request to launch a MULT/MULTU/DIV/DIVU.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 src_a  input  32  rs operand (multiplicand/dividend; MTHI/MTLO data).
REQ-007 src_b  input  32  rt operand (multiplier/divisor).
REQ-008 mthi  input  1  write src_a to HI.
REQ-009 mtlo  input  1  write src_a to LO.
REQ-010 flush  input  1  abort the in-flight operation (exception/flush_ex).
REQ-011 busy  output  1  operation in progress; the hazard unit stalls MFHI/MFLO/MTHI/MTLO and new mult/div on it.
REQ-012 done  output  1  one-cycle pulse when HI/LO take a new result.
REQ-013 hi  output  32  HI register.
REQ-014 lo  output  32  LO register.

Function
REQ-015 FSM states SHALL be IDLE and RUN; IDLE->RUN on start, RUN->IDLE after 32 iterations or on flush.
REQ-016 start sampled high in IDLE at cycle T SHALL latch op/src_a/src_b; busy high in cycles T+1..T+32; hi/lo hold the result and done=1 in cycle T+33; busy=0 in T+33.
REQ-017 Multiply SHALL be iterative shift-add, one bit per cycle; 64-bit product: hi=[63:32], lo=[31:0].
REQ-018 Divide SHALL be iterative restoring, one quotient bit per cycle; lo=quotient, hi=remainder.
REQ-019 Signed ops SHALL operate on magnitudes and fix signs at completion; quotient truncates toward zero, remainder takes the sign of the dividend.
REQ-020 Divide by zero (either signedness) SHALL give lo=32'hFFFF_FFFF, hi=src_a as latched.
REQ-021 DIV 32'h8000_0000 / 32'hFFFF_FFFF SHALL give lo=32'h8000_0000, hi=0.
REQ-022 start while busy SHALL be ignored; operands are not re-latched.
REQ-023 mthi/mtlo in IDLE SHALL update hi/lo at the next edge; both high updates both; done stays 0.
REQ-024 mthi/mtlo while busy SHALL be ignored.
REQ-025 start and mthi/mtlo in the same IDLE cycle: start wins, the move is dropped.
REQ-026 flush in RUN SHALL return to IDLE at the next edge, busy=0, hi/lo unchanged, no done pulse; flush in IDLE SHALL suppress a same-cycle start.
REQ-027 hi/lo SHALL change only on done, mthi/mtlo or rst.

Reset
REQ-028 rst SHALL force IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0 at the next edge, including mid-operation; rst overrides start, flush and mthi/mtlo.

Configuration
REQ-029 Macro MDU_DIV_EN defined: DIV/DIVU SHALL be implemented per REQ-018..021.
REQ-030 Macro MDU_DIV_EN undefined: the divider datapath SHALL be omitted; a start with op[1]=1 is a no-op (stays IDLE, busy=0, no done, hi/lo unchanged).

Verification
REQ-031 MULTU 0xFFFF_FFFF * 0xFFFF_FFFF, start at T -> busy T+1..T+32; done at T+33; hi=0xFFFF_FFFE, lo=0x0000_0001.
REQ-032 MULT 0xFFFF_FFFE (-2) * 3 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFFA; DIV -7 / 2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
REQ-033 DIVU 100 / 0 -> lo=0xFFFF_FFFF, hi=100; DIV 0x8000_0000 / -1 -> lo=0x8000_0000, hi=0.
REQ-034 MTHI 0x1234 then MULTU 2*3 starting next cycle with a new start asserted again at T+5 -> hi=0 after done, lo=6, the second start ignored, one done pulse.
REQ-035 Start DIVU at T, flush at T+10 -> busy=0 at T+11, hi/lo keep prior values, no done; rst asserted at T+5 of a new operation -> hi=lo=0, busy=0 next cycle.
REQ-036 Build without MDU_DIV_EN: DIV 10/3 -> busy stays 0, no done, hi/lo unchanged; MULTU still per REQ-031.
